// File: rtl/gray2rgb_stream_tx_if.sv
// Handshake bundle for gray2rgb_stream_tx: gray pixel input, pixel-transform
// controls, and the Avalon-ST RGB byte source with frame strobe.
interface gray2rgb_stream_tx_if;
    logic [7:0] GrayData_i;
    logic       GrayValid_i;
    logic       GrayReady_o;
    logic       BinaryMode_i;
    logic [7:0] Threshold_i;
    logic [7:0] RgbData_o;
    logic       RgbValid_o;
    logic       RgbReady_i;
    logic       RgbSop_o;
    logic       RgbEop_o;
    logic       FrameDone_o;

    modport master (
        output GrayData_i, GrayValid_i, BinaryMode_i, Threshold_i, RgbReady_i,
        input  GrayReady_o, RgbData_o, RgbValid_o, RgbSop_o, RgbEop_o, FrameDone_o
    );

    modport slave (
        input  GrayData_i, GrayValid_i, BinaryMode_i, Threshold_i, RgbReady_i,
        output GrayReady_o, RgbData_o, RgbValid_o, RgbSop_o, RgbEop_o, FrameDone_o
    );
endinterface

// File: rtl/gray2rgb_stream_tx.sv
// Gray-to-RGB stream transmitter: each accepted gray pixel (optionally
// thresholded) is replicated into R, G, B byte beats framed per image.
module gray2rgb_stream_tx #(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    gray2rgb_stream_tx_if.slave  bus
);
    localparam int unsigned FRAME_PIX = IMG_WIDTH * IMG_HEIGHT;
    localparam int unsigned PIX_W     = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(FRAME_PIX - 1);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t           state, stateNext;
    logic [1:0]       beat, beatNext;
    logic [7:0]       held, heldNext;
    logic [PIX_W-1:0] pixel, pixelNext;
    logic             frameDone, frameDoneNext;
    logic             lastBeat, beatAcc, grayReady, grayAcc;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            beat      <= '0;
            held      <= '0;
            pixel     <= '0;
            frameDone <= 1'b0;
        end else begin
            state     <= stateNext;
            beat      <= beatNext;
            held      <= heldNext;
            pixel     <= pixelNext;
            frameDone <= frameDoneNext;
        end
    end

    always_comb begin
        lastBeat  = (beat == 2'd2);
        beatAcc   = (state == EMIT) & bus.RgbReady_i;
        // Reload on the B beat's accept keeps the output stream bubble-free.
        grayReady = rst_i & ((state == IDLE) | (lastBeat & bus.RgbReady_i));
        grayAcc   = bus.GrayValid_i & grayReady;

        stateNext     = state;
        beatNext      = beat;
        heldNext      = held;
        pixelNext     = pixel;
        frameDoneNext = 1'b0;

        if (beatAcc) begin
            if (lastBeat) begin
                stateNext     = IDLE;
                beatNext      = '0;
                pixelNext     = (pixel == LAST_PIX) ? '0 : pixel + PIX_W'(1);
                frameDoneNext = (pixel == LAST_PIX);
            end else begin
                beatNext = beat + 2'd1;
            end
        end

        if (grayAcc) begin
            stateNext = EMIT;
            beatNext  = '0;
            if (bus.BinaryMode_i)
                heldNext = (bus.GrayData_i >= bus.Threshold_i) ? '1 : '0;
            else
                heldNext = bus.GrayData_i;
        end
    end

    assign bus.GrayReady_o = grayReady;
    assign bus.RgbValid_o  = (state == EMIT);
    assign bus.RgbData_o   = (state == EMIT) ? held : '0;
    assign bus.RgbSop_o    = (state == EMIT) & (beat == 2'd0) & (pixel == '0);
    assign bus.RgbEop_o    = (state == EMIT) & lastBeat & (pixel == LAST_PIX);
    assign bus.FrameDone_o = frameDone;
endmodule

// File: tb/tb_gray2rgb_stream_tx.sv
// Scoreboard bench for gray2rgb_stream_tx on a 2x2 frame.
module tb_gray2rgb_stream_tx;
    localparam int W     = 2;
    localparam int H     = 2;
    localparam int FRAME = W * H;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    gray2rgb_stream_tx_if bus ();

    gray2rgb_stream_tx #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       sop;
        logic       eop;
    } beat_t;

    beat_t expQ[$];
    beat_t monE;
    int    compared = 0;
    int    mismatched = 0;
    int    modelPix = 0;
    bit    pendDone = 1'b0;
    int    doneCnt = 0, sopCnt = 0, eopCnt = 0, beatCnt = 0;
    int    cycle = 0, sopCycle = 0, eopCycle = 0;
    bit    randDone = 1'b0;
    logic [7:0] monV;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: sampled on the falling edge, between input changes and the active edge.
    always @(negedge clk) begin
        cycle++;
        if (!rst) begin
            expQ.delete();
            modelPix = 0;
            pendDone = 1'b0;
        end else begin
            checkVal("frame_done", bus.FrameDone_o, pendDone);
            if (bus.FrameDone_o) doneCnt++;
            pendDone = 1'b0;
            if (bus.RgbValid_o && bus.RgbReady_i) begin
                checkVal("beat_expected", expQ.size() != 0, 1);
                if (expQ.size() != 0) begin
                    monE = expQ.pop_front();
                    checkVal("rgb_data", bus.RgbData_o, monE.d);
                    checkVal("rgb_sop", bus.RgbSop_o, monE.sop);
                    checkVal("rgb_eop", bus.RgbEop_o, monE.eop);
                    if (monE.eop) pendDone = 1'b1;
                end
                beatCnt++;
                if (bus.RgbSop_o) begin sopCnt++; sopCycle = cycle; end
                if (bus.RgbEop_o) begin eopCnt++; eopCycle = cycle; end
            end
            if (bus.GrayValid_i && bus.GrayReady_o) begin
                if (bus.BinaryMode_i)
                    monV = (bus.GrayData_i >= bus.Threshold_i) ? 8'hFF : 8'h00;
                else
                    monV = bus.GrayData_i;
                expQ.push_back('{d: monV, sop: (modelPix == 0), eop: 1'b0});
                expQ.push_back('{d: monV, sop: 1'b0, eop: 1'b0});
                expQ.push_back('{d: monV, sop: 1'b0, eop: (modelPix == FRAME - 1)});
                modelPix = (modelPix + 1) % FRAME;
            end
        end
    end

    // Call just after a rising edge; returns just after the accepting edge.
    task automatic sendPixel(input logic [7:0] p);
        bit ok;
        ok = 1'b0;
        bus.GrayData_i  = p;
        bus.GrayValid_i = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.GrayReady_o) begin ok = 1'b1; break; end
        end
        checkVal("accept_in_time", ok, 1);
        @(posedge clk); #1;
        bus.GrayValid_i = 1'b0;
    endtask

    task automatic waitDrain();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (expQ.size() == 0 && !bus.RgbValid_o) begin ok = 1'b1; break; end
        end
        checkVal("drain_in_time", ok, 1);
        @(negedge clk);
        @(posedge clk); #1;
    endtask

    initial begin
        int d0, s0, e0, b0;
        bus.GrayData_i   = '0;
        bus.GrayValid_i  = 1'b0;
        bus.BinaryMode_i = 1'b0;
        bus.Threshold_i  = '0;
        bus.RgbReady_i   = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkVal("rst_valid", bus.RgbValid_o, 0);
        checkVal("rst_data", bus.RgbData_o, 0);
        checkVal("rst_sop", bus.RgbSop_o, 0);
        checkVal("rst_eop", bus.RgbEop_o, 0);
        checkVal("rst_done", bus.FrameDone_o, 0);
        checkVal("rst_gray_ready", bus.GrayReady_o, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        bus.RgbReady_i = 1'b1;
        @(negedge clk);
        checkVal("ready_after_rst", bus.GrayReady_o, 1);
        @(posedge clk); #1;

        // Pass-through frame, full rate
        d0 = doneCnt; s0 = sopCnt; e0 = eopCnt; b0 = beatCnt;
        sendPixel(8'h10); sendPixel(8'h20); sendPixel(8'h30); sendPixel(8'h40);
        waitDrain();
        checkVal("t1_beats", beatCnt - b0, 12);
        checkVal("t1_no_gaps", eopCycle - sopCycle, 11);
        checkVal("t1_sops", sopCnt - s0, 1);
        checkVal("t1_eops", eopCnt - e0, 1);
        checkVal("t1_done", doneCnt - d0, 1);

        // Binary mode, threshold boundary, second consecutive frame
        bus.BinaryMode_i = 1'b1;
        bus.Threshold_i  = 8'h80;
        sendPixel(8'h7F); sendPixel(8'h80); sendPixel(8'hFF); sendPixel(8'h00);
        bus.BinaryMode_i = 1'b0;
        waitDrain();
        checkVal("t2_done_total", doneCnt, 2);
        checkVal("t2_sop_total", sopCnt, 2);

        // Backpressure on the G beat
        sendPixel(8'hAB);
        @(posedge clk); #1;
        bus.RgbReady_i = 1'b0;
        repeat (5) begin
            @(negedge clk);
            checkVal("bp_data", bus.RgbData_o, 8'hAB);
            checkVal("bp_valid", bus.RgbValid_o, 1);
            checkVal("bp_gray_ready", bus.GrayReady_o, 0);
        end
        @(posedge clk); #1;
        bus.RgbReady_i = 1'b1;
        @(negedge clk);
        checkVal("bp_g_beat", bus.GrayReady_o, 0);
        @(negedge clk);
        checkVal("bp_b_beat_next", bus.GrayReady_o, 1);
        checkVal("bp_b_data", bus.RgbData_o, 8'hAB);
        @(posedge clk); #1;
        sendPixel(8'h01); sendPixel(8'h02); sendPixel(8'h03);
        waitDrain();
        checkVal("t3_done_total", doneCnt, 3);

        // Reset in the middle of a frame
        sendPixel(8'h11); sendPixel(8'h22);
        @(posedge clk); #2;
        rst = 1'b0;
        d0 = doneCnt;
        @(negedge clk);
        checkVal("mid_rst_valid", bus.RgbValid_o, 0);
        checkVal("mid_rst_data", bus.RgbData_o, 0);
        checkVal("mid_rst_sop", bus.RgbSop_o, 0);
        checkVal("mid_rst_eop", bus.RgbEop_o, 0);
        checkVal("mid_rst_done", bus.FrameDone_o, 0);
        checkVal("mid_rst_gray_ready", bus.GrayReady_o, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checkVal("aborted_no_done", doneCnt - d0, 0);
        @(posedge clk); #1;
        s0 = sopCnt; e0 = eopCnt; b0 = beatCnt;
        sendPixel(8'h31); sendPixel(8'h32); sendPixel(8'h33); sendPixel(8'h34);
        waitDrain();
        checkVal("t4_beats", beatCnt - b0, 12);
        checkVal("t4_sops", sopCnt - s0, 1);
        checkVal("t4_eops", eopCnt - e0, 1);
        checkVal("t4_done", doneCnt - d0, 1);

        // Random valid/ready over 10 frames
        d0 = doneCnt; s0 = sopCnt; e0 = eopCnt; b0 = beatCnt;
        fork
            begin
                for (int i = 0; i < 10 * FRAME; i++) begin
                    while ($urandom_range(0, 1) == 1) begin
                        @(posedge clk); #1;
                    end
                    sendPixel(8'($urandom_range(0, 255)));
                end
                randDone = 1'b1;
            end
            begin
                while (!randDone) begin
                    @(posedge clk); #1;
                    bus.RgbReady_i = ($urandom_range(0, 1) == 1);
                end
                bus.RgbReady_i = 1'b1;
            end
        join
        waitDrain();
        checkVal("t5_beats", beatCnt - b0, 120);
        checkVal("t5_sops", sopCnt - s0, 10);
        checkVal("t5_eops", eopCnt - e0, 10);
        checkVal("t5_done", doneCnt - d0, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end
endmodule

// File: doc/gray2rgb_stream_tx.md
# gray2rgb_stream_tx

Streaming transmitter that returns processed grayscale pixels to the RGB domain. It accepts one 8-bit gray pixel per handshake from the edge-detection datapath. It emits each pixel as three byte beats (R, G, B) on an Avalon-ST source with start/end-of-packet framing, one packet per image. The block sits at the output end of the filter, mirroring the RGB-to-gray conversion at the input.

## Interface

Parameters:
- IMG_WIDTH, 64, pixels per line
- IMG_HEIGHT, 64, lines per frame; frame length is IMG_WIDTH*IMG_HEIGHT pixels

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- GrayData_i  in  8  input gray pixel
- GrayValid_i  in  1  input pixel valid
- GrayReady_o  out  1  block can accept a pixel this cycle
- BinaryMode_i  in  1  1: threshold the pixel; 0: pass it through
- Threshold_i  in  8  threshold used in binary mode
- RgbData_o  out  8  output byte (R, then G, then B)
- RgbValid_o  out  1  output beat valid
- RgbReady_i  in  1  sink accepts the beat (readyLatency 0)
- RgbSop_o  out  1  first beat of frame
- RgbEop_o  out  1  last beat of frame
- FrameDone_o  out  1  one-cycle pulse after the frame's last beat is accepted

## Operation

- Holding register: one gray byte plus a full flag.
- Beat counter: 0..2, selects R/G/B.
- Pixel counter: 0..IMG_WIDTH*IMG_HEIGHT-1.
- Pixel transform at accept (GrayValid_i & GrayReady_o):
  - BinaryMode_i=1: held = (GrayData_i >= Threshold_i) ? 8'hFF : 8'h00.
  - BinaryMode_i=0: held = GrayData_i.
  - BinaryMode_i and Threshold_i are sampled only at accept.
- All three beats carry the held value (grayscale replication).
- States:
  - IDLE (not full): RgbValid_o=0. An accept moves to EMIT with beat=0.
  - EMIT (full): RgbValid_o=1. Each beat accepted (RgbValid_o & RgbReady_i) increments beat.
  - The accept of beat 2 either stays in EMIT with beat=0 (if a new pixel is accepted the same cycle) or goes to IDLE.
- GrayReady_o = rst_i & (~full | (beat==2 & RgbReady_i)). This is combinational, so the block sustains one pixel per 3 cycles with no bubble.
- RgbSop_o = full & beat==0 & pixel==0.
- RgbEop_o = full & beat==2 & pixel==last.
- Pixel counter increments on acceptance of beat 2. It wraps from last to 0 on the Eop beat.
- FrameDone_o is registered and asserts the cycle after the Eop beat is accepted.
- The block does not check GrayData_i framing; the pixel count alone defines frame boundaries.

## Timing

- Reset (rst_i low, asynchronous):
  - full=0, beat=0, pixel=0, state IDLE.
  - RgbValid_o=0, RgbData_o=0, RgbSop_o=0, RgbEop_o=0, FrameDone_o=0.
  - GrayReady_o=0 while rst_i is low and 1 in the first cycle after release.
- Latency: a pixel accepted at edge N presents its R beat with RgbValid_o=1 after edge N (cycle N+1).
- Backpressure: while RgbValid_o=1 and RgbReady_i=0, RgbData_o, RgbSop_o, RgbEop_o and beat hold unchanged. GrayReady_o=0 in this case.
- Simultaneous events: accepting beat 2 and a new pixel in the same cycle loads the new value. The next beat is the new pixel's R, and there is no idle cycle.
- Reset mid-frame: any partial pixel or frame is discarded. The next accepted pixel starts a new frame with RgbSop_o=1, and no FrameDone_o is issued for the aborted frame.
- Throughput: 3 output beats per pixel. Full rate with RgbReady_i held at 1 is one pixel every 3 cycles.

## Test plan

- Use IMG_WIDTH=2, IMG_HEIGHT=2 unless noted.
- Single frame, pass mode, RgbReady_i=1:
  - Stimulus: pixels 8'h10, 8'h20, 8'h30, 8'h40 offered back-to-back.
  - Required: 12 beats 10,10,10,20,20,20,30,30,30,40,40,40 with no gaps.
  - Required: Sop on beat 1 only, Eop on beat 12 only, FrameDone_o pulse on the cycle after beat 12.
- Binary mode with Threshold_i=8'h80:
  - Stimulus: pixels 7F, 80, FF, 00.
  - Required: beats 00×3, FF×3, FF×3, 00×3.
- Backpressure:
  - Stimulus: RgbReady_i low for 5 cycles during the G beat of pixel 8'hAB.
  - Required: RgbData_o=AB held stable with RgbValid_o=1 and GrayReady_o=0.
  - Required: the B beat follows the cycle after RgbReady_i returns high.
- Two consecutive frames:
  - Required: Sop reasserts on the first beat of frame 2.
  - Required: the pixel counter wraps and FrameDone_o pulses exactly twice.
- Reset mid-frame:
  - Stimulus: assert rst_i low after 2 pixels of frame 1 (mid-beat), then release and send 4 pixels.
  - Required: all outputs 0 during reset, no FrameDone_o for the aborted frame.
  - Required: the new frame starts with Sop and ends with Eop after 12 beats.
- Random valid/ready:
  - Stimulus: random GrayValid_i and RgbReady_i at 50% over 10 frames.
  - Required: the output byte sequence equals each input pixel ×3 in order.
  - Required: every frame has exactly one Sop and one Eop.
